// File: rtl/aes_pkg.sv
// Shared AES definitions for the key schedule blocks.
//
// Contents:
//   ks_state_e - key schedule sequencer states (idle, forward expansion, reverse emission)
//   AES_NR     - number of AES-128 rounds
//   RCON       - round constants for rounds 1..10 (byte value, XORed into byte 0 of a word)
//   get_word / get_byte / pack_words / rot_word / rcon_of - slicing and word helpers
//
// Byte packing throughout: byte i of a block at [8i+7:8i], word j at [32j+31:32j],
// so byte 0 (row 0, col 0) sits in the LSB.
package aes_pkg;

    localparam logic [3:0] AES_NR = 4'd10;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StFwd  = 2'd1,
        StRev  = 2'd2
    } ks_state_e;

    localparam logic [7:0] RCON [1:10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    // Word j (0..3) of a 128-bit block.
    function automatic logic [31:0] get_word(input logic [127:0] blk, input logic [1:0] j);
        return blk[{j, 5'b00000} +: 32];
    endfunction

    // Byte i (0..3) of a 32-bit word.
    function automatic logic [7:0] get_byte(input logic [31:0] w, input logic [1:0] i);
        return w[{i, 3'b000} +: 8];
    endfunction

    function automatic logic [127:0] pack_words(input logic [31:0] w0, input logic [31:0] w1,
                                                input logic [31:0] w2, input logic [31:0] w3);
        return {w3, w2, w1, w0};
    endfunction

    // RotWord: byte 0 moves to position 3, giving {b0,b3,b2,b1} in LSB packing.
    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[7:0], w[31:8]};
    endfunction

    // Round constant for round r; rounds outside 1..10 contribute nothing.
    function automatic logic [7:0] rcon_of(input logic [3:0] r);
        logic [7:0] rc;
        rc = 8'h00;
        if (r >= 4'd1 && r <= AES_NR) begin
            rc = RCON[r];
        end
        return rc;
    endfunction

endpackage

// File: rtl/inv_key_schedule_if.sv
// Handshake bundle between the decryption key schedule and its neighbours.
//
// Signals:
//   key_in[127:0]  cipher key               key_valid  key_in valid
//   key_ready      schedule idle, accepts a new key
//   rk_out[127:0]  current round key        rk_round[3:0]  round index of rk_out (10..0)
//   rk_last        final key (round 0)      rk_valid  rk_out valid
//   rk_ready       consumer accepts rk_out
//
// Modports:
//   master - key source / round key consumer (drives key_in, key_valid, rk_ready)
//   slave  - the key schedule itself
interface inv_key_schedule_if;

    logic [127:0] key_in;
    logic         key_valid;
    logic         key_ready;
    logic [127:0] rk_out;
    logic [3:0]   rk_round;
    logic         rk_last;
    logic         rk_valid;
    logic         rk_ready;

    modport master (
        output key_in,
        output key_valid,
        output rk_ready,
        input  key_ready,
        input  rk_out,
        input  rk_round,
        input  rk_last,
        input  rk_valid
    );

    modport slave (
        input  key_in,
        input  key_valid,
        input  rk_ready,
        output key_ready,
        output rk_out,
        output rk_round,
        output rk_last,
        output rk_valid
    );

endinterface

// File: rtl/aes_sbox.sv
// AES forward S-box, purely combinational. Shared with the encryption SubBytes path.
//
// Ports:
//   din[7:0]  input byte
//   dout[7:0] substituted byte
//
// The table is held as 16 rows of 16 bytes; the high nibble picks the row and the low
// nibble picks the byte, with column 0 in the most significant byte of the row.
module aes_sbox (
    input  logic [7:0] din,
    output logic [7:0] dout
);

    localparam logic [127:0] SBOX_ROWS [16] = '{
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [127:0] row;

    always_comb begin
        row  = SBOX_ROWS[din[7:4]];
        // Column c lives at bit offset 8*(15-c); ~c is 15-c for a 4-bit value.
        dout = row[{~din[3:0], 3'b000} +: 8];
    end

endmodule

// File: rtl/inv_key_schedule.sv
// Iterative AES-128 decryption key generator.
//
// A cipher key is accepted in idle, expanded forward to round key 10 (one round per cycle),
// then round keys 10 down to 0 are emitted one per rk_valid/rk_ready handshake by running
// the expansion backwards. Only a single 128-bit key register is kept.
//
// Ports:
//   clk  - system clock, rising edge
//   rst  - synchronous, active-high reset
//   bus  - inv_key_schedule_if.slave: key_in/key_valid/key_ready in, rk_out/rk_round/
//          rk_last/rk_valid/rk_ready out
//
// Timing with rk_ready held high: key accepted at the end of cycle 0, forward expansion in
// cycles 1..10, round keys 10..0 in cycles 11..21, idle again in cycle 22.
module inv_key_schedule (
    input  logic                  clk,
    input  logic                  rst,
    inv_key_schedule_if.slave     bus
);

    import aes_pkg::*;

    ks_state_e    state_q, state_d;
    logic [127:0] key_reg_q, key_reg_d;
    logic [3:0]   rnd_q, rnd_d;

    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  sub_in;
    logic [31:0]  rot_in;
    logic [31:0]  sub_out;
    logic [127:0] fwd_key;
    logic [127:0] inv_key;
    logic         rk_hs;

    // ------------------------------------------------------------------
    // Shared SubWord. In reverse mode the previous round's w3 is rebuilt as w3^w2, so the
    // same four S-boxes serve both directions.
    // ------------------------------------------------------------------
    always_comb begin
        w0     = get_word(key_reg_q, 2'd0);
        w1     = get_word(key_reg_q, 2'd1);
        w2     = get_word(key_reg_q, 2'd2);
        w3     = get_word(key_reg_q, 2'd3);
        sub_in = (state_q == StRev) ? (w3 ^ w2) : w3;
        rot_in = rot_word(sub_in);
    end

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        aes_sbox u_sbox (
            .din  (rot_in[8*b +: 8]),
            .dout (sub_out[8*b +: 8])
        );
    end

    // ------------------------------------------------------------------
    // Forward and inverse round transforms.
    // ------------------------------------------------------------------
    always_comb begin
        logic [31:0] n0, n1, n2, n3;
        logic [31:0] p0, p1, p2, p3;

        n0      = w0 ^ sub_out ^ {24'h000000, rcon_of(rnd_q + 4'd1)};
        n1      = n0 ^ w1;
        n2      = n1 ^ w2;
        n3      = n2 ^ w3;
        fwd_key = pack_words(n0, n1, n2, n3);

        p3      = w3 ^ w2;
        p2      = w2 ^ w1;
        p1      = w1 ^ w0;
        p0      = w0 ^ sub_out ^ {24'h000000, rcon_of(rnd_q)};
        inv_key = pack_words(p0, p1, p2, p3);
    end

    // ------------------------------------------------------------------
    // Sequencer: next state
    // ------------------------------------------------------------------
    assign rk_hs = (state_q == StRev) && bus.rk_ready;

    always_comb begin
        state_d   = state_q;
        key_reg_d = key_reg_q;
        rnd_d     = rnd_q;

        unique case (state_q)
            StIdle: begin
                if (bus.key_valid) begin
                    key_reg_d = bus.key_in;
                    rnd_d     = 4'd0;
                    state_d   = StFwd;
                end
            end
            StFwd: begin
                key_reg_d = fwd_key;
                rnd_d     = rnd_q + 4'd1;
                if (rnd_q == AES_NR - 4'd1) begin
                    state_d = StRev;
                end
            end
            StRev: begin
                if (rk_hs) begin
                    if (rnd_q != 4'd0) begin
                        key_reg_d = inv_key;
                        rnd_d     = rnd_q - 4'd1;
                    end else begin
                        // Round 0 consumed; key_reg keeps the cipher key until the next load.
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            key_reg_q <= '0;
            rnd_q     <= '0;
        end else begin
            state_q   <= state_d;
            key_reg_q <= key_reg_d;
            rnd_q     <= rnd_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.key_ready = (state_q == StIdle);
    assign bus.rk_valid  = (state_q == StRev);
    assign bus.rk_out    = key_reg_q;
    assign bus.rk_round  = rnd_q;
    assign bus.rk_last   = (state_q == StRev) && (rnd_q == 4'd0);

endmodule

// File: tb/tb_inv_key_schedule.sv
// Self-checking bench for inv_key_schedule: table of directed vectors plus hand-written
// sequences for backpressure, mid-run reset and back-to-back keys. The reference round keys
// come from a forward AES-128 expansion using an S-box derived from GF(2^8) inversion.
module tb_inv_key_schedule;

    logic clk;
    logic rst;

    inv_key_schedule_if bus ();

    inv_key_schedule dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_pass  = 0;
    int n_total = 0;

    localparam logic [127:0] K_FIPS  = 128'h3c4fcf09_8815f7ab_a6d2ae28_16157e2b;
    localparam logic [127:0] K_FIPS9 = 128'h6e005c57_4129d128_21dcfa19_f36677ac;
    localparam logic [127:0] K_FIPS10 = 128'ha60c63b6_c80c3fe1_8925eec9_a8f914d0;
    localparam logic [127:0] K_FIPS1 = 128'h05766c2a_3939a323_b12c5488_17fefaa0;
    localparam logic [127:0] K_ZERO10 = 128'h8e188f6f_cf51e923_11e2923e_cb5befb4;

    // ---------------- reference model ----------------
    logic [7:0] sbox_tab [256];

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in;
        b = b_in;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv, x;
        for (int v = 0; v < 256; v++) begin
            x   = v[7:0];
            inv = 8'h00;
            if (x != 8'h00) begin
                inv = 8'h01;
                for (int e = 0; e < 254; e++) inv = gmul(inv, x);
            end
            sbox_tab[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                          ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    // Round key r of cipher key k, by forward expansion from round 0.
    function automatic logic [127:0] ref_rk(input logic [127:0] k, input int r);
        logic [31:0] w [4];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int j = 0; j < 4; j++) w[j] = k[32*j +: 32];
        for (int i = 1; i <= r; i++) begin
            t = {w[3][7:0], w[3][31:8]};
            t = {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]};
            t[7:0] = t[7:0] ^ rc;
            w[0] = w[0] ^ t;
            w[1] = w[1] ^ w[0];
            w[2] = w[2] ^ w[1];
            w[3] = w[3] ^ w[2];
            rc = rc[7] ? ((rc << 1) ^ 8'h1b) : (rc << 1);
        end
        return {w[3], w[2], w[1], w[0]};
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic timeout_fail(input string name);
        n_total++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // Leaves the bench at the negedge just after the reset edge (cycle 0 of the next key).
    task automatic do_reset();
        @(negedge clk);
        rst           = 1'b1;
        bus.key_valid = 1'b0;
        bus.rk_ready  = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Presents k for one accepting edge; returns at the negedge of cycle 1.
    task automatic start_key(input logic [127:0] k);
        int waited;
        waited = 0;
        while (!bus.key_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.key_ready) timeout_fail("start_key");
        bus.key_in    = k;
        bus.key_valid = 1'b1;
        @(negedge clk);
        bus.key_valid = 1'b0;
    endtask

    typedef struct {
        string        name;
        logic [127:0] key;
        int           cyc;
        logic         ready;
        logic         valid;
        logic [3:0]   rnd;
        logic         last;
        logic [127:0] rk;
    } vec_t;

    vec_t tbl [8];

    // ---------------- stimulus ----------------
    initial begin
        logic [127:0] k, kb, prev_out;
        int           r, bound, cnt;
        logic         done, prev_stall, hs;
        int           acc [$];

        rst           = 1'b1;
        bus.key_in    = '0;
        bus.key_valid = 1'b0;
        bus.rk_ready  = 1'b1;
        build_sbox();

        tbl[0] = '{"fips_c1",  K_FIPS,  1, 1'b0, 1'b0, 4'd0,  1'b0, K_FIPS};
        tbl[1] = '{"fips_c10", K_FIPS, 10, 1'b0, 1'b0, 4'd9,  1'b0, K_FIPS9};
        tbl[2] = '{"fips_c11", K_FIPS, 11, 1'b0, 1'b1, 4'd10, 1'b0, K_FIPS10};
        tbl[3] = '{"fips_c20", K_FIPS, 20, 1'b0, 1'b1, 4'd1,  1'b0, K_FIPS1};
        tbl[4] = '{"fips_c21", K_FIPS, 21, 1'b0, 1'b1, 4'd0,  1'b1, K_FIPS};
        tbl[5] = '{"fips_c22", K_FIPS, 22, 1'b1, 1'b0, 4'd0,  1'b0, K_FIPS};
        tbl[6] = '{"zero_c11", '0,     11, 1'b0, 1'b1, 4'd10, 1'b0, K_ZERO10};
        tbl[7] = '{"zero_c21", '0,     21, 1'b0, 1'b1, 4'd0,  1'b1, '0};

        // Reset state
        do_reset();
        check("rst_key_ready", 128'(bus.key_ready), 128'd1);
        check("rst_rk_valid",  128'(bus.rk_valid),  128'd0);
        check("rst_rk_out",    bus.rk_out,          128'd0);
        check("rst_rk_round",  128'(bus.rk_round),  128'd0);
        check("rst_rk_last",   128'(bus.rk_last),   128'd0);

        // Directed table, rk_ready held high
        for (int v = 0; v < 8; v++) begin
            do_reset();
            start_key(tbl[v].key);
            repeat (tbl[v].cyc - 1) @(negedge clk);
            check({tbl[v].name, "_ready"}, 128'(bus.key_ready), 128'(tbl[v].ready));
            check({tbl[v].name, "_valid"}, 128'(bus.rk_valid),  128'(tbl[v].valid));
            check({tbl[v].name, "_round"}, 128'(bus.rk_round),  128'(tbl[v].rnd));
            check({tbl[v].name, "_last"},  128'(bus.rk_last),   128'(tbl[v].last));
            check({tbl[v].name, "_rk"},    bus.rk_out,          tbl[v].rk);
        end

        // Random backpressure across all 11 rounds
        do_reset();
        k = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
        start_key(k);
        r          = 10;
        done       = 1'b0;
        prev_stall = 1'b0;
        prev_out   = '0;
        bound      = 0;
        while (!done && bound < 400) begin
            if (bus.rk_valid) begin
                if (prev_stall) check("stall_hold", bus.rk_out, prev_out);
                check("stall_rk",    bus.rk_out,         ref_rk(k, r));
                check("stall_round", 128'(bus.rk_round), 128'(r));
            end
            bus.rk_ready = ($urandom_range(0, 2) == 0);
            hs           = bus.rk_valid && bus.rk_ready;
            prev_stall   = bus.rk_valid && !bus.rk_ready;
            prev_out     = bus.rk_out;
            if (hs) begin
                if (r == 0) done = 1'b1;
                else r--;
            end
            @(negedge clk);
            bound++;
        end
        if (!done) timeout_fail("stall_seq");
        check("stall_end_ready", 128'(bus.key_ready), 128'd1);
        check("stall_end_valid", 128'(bus.rk_valid),  128'd0);
        bus.rk_ready = 1'b1;

        // Reset while emitting round 5, then a fresh key runs clean
        do_reset();
        start_key(K_FIPS);
        cnt = 0;
        while (!(bus.rk_valid && bus.rk_round == 4'd5) && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        check("rst5_round", 128'(bus.rk_round), 128'd5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst5_valid", 128'(bus.rk_valid),  128'd0);
        check("rst5_ready", 128'(bus.key_ready), 128'd1);
        check("rst5_rk",    bus.rk_out,          128'd0);
        kb = 128'h00112233_44556677_8899aabb_ccddeeff;
        start_key(kb);
        repeat (10) @(negedge clk);
        for (int rr = 10; rr >= 0; rr--) begin
            check("post_rst_valid", 128'(bus.rk_valid), 128'd1);
            check("post_rst_round", 128'(bus.rk_round), 128'(rr));
            check("post_rst_rk",    bus.rk_out,         ref_rk(kb, rr));
            @(negedge clk);
        end

        // key_valid held high: accepted only when idle, key change during FWD ignored
        do_reset();
        kb            = 128'hdeadbeef_01234567_89abcdef_cafef00d;
        bus.key_in    = K_FIPS;
        bus.key_valid = 1'b1;
        bus.rk_ready  = 1'b1;
        for (int c = 0; c <= 44; c++) begin
            if (c == 3) bus.key_in = kb;
            if (bus.key_ready) acc.push_back(c);
            if (c >= 11 && c <= 21) begin
                check("b2b_a_round", 128'(bus.rk_round), 128'(21 - c));
                check("b2b_a_rk",    bus.rk_out,         ref_rk(K_FIPS, 21 - c));
            end
            if (c >= 33 && c <= 43) begin
                check("b2b_b_round", 128'(bus.rk_round), 128'(43 - c));
                check("b2b_b_rk",    bus.rk_out,         ref_rk(kb, 43 - c));
            end
            @(negedge clk);
        end
        bus.key_valid = 1'b0;
        check("b2b_accepts", 128'(acc.size()), 128'd3);
        if (acc.size() == 3) begin
            check("b2b_acc0", 128'(acc[0]), 128'd0);
            check("b2b_acc1", 128'(acc[1]), 128'd22);
            check("b2b_acc2", 128'(acc[2]), 128'd44);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
        $fatal(1, "watchdog expired");
    end

endmodule
